// File: rtl/iob_cache_axil_bridge.sv
// Bridges the cache back-end native memory port onto an AXI4-Lite master.
// One native request becomes exactly one AXI4-Lite transaction; slave errors raise a sticky flag.
module iob_cache_axil_bridge #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter int          NBYTES = DATA_W / 8,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NBYTES-1:0] wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,

  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [NBYTES-1:0] m_axi_wstrb,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,

  output logic              error,
  input  logic              error_clr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WAIT_B = 3'd2,
    RD     = 3'd3,
    WAIT_R = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NBYTES - 1);
  localparam logic [1:0]        RESP_OKAY  = 2'b00;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                error_q, error_d;

  logic                accept;
  logic                aw_done;
  logic                w_done;
  logic                b_capture;
  logic                r_capture;

  // A channel counts as done once its valid has dropped or is handshaking this cycle.
  assign accept    = (state_q == IDLE) && valid;
  assign aw_done   = !awvalid_q || m_axi_awready;
  assign w_done    = !wvalid_q || m_axi_wready;
  assign b_capture = (state_q == WAIT_B) && m_axi_bvalid;
  assign r_capture = (state_q == WAIT_R) && m_axi_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = (|wstrb) ? WR : RD;
        end
      end
      WR: begin
        if (aw_done && w_done) begin
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (m_axi_bvalid) begin
          state_d = RESP;
        end
      end
      RD: begin
        if (m_axi_arready) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (m_axi_rvalid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    ready         = 1'b0;
    case (state_q)
      RD:      m_axi_arvalid = 1'b1;
      WAIT_B:  m_axi_bready  = 1'b1;
      WAIT_R:  m_axi_rready  = 1'b1;
      RESP:    ready         = 1'b1;
      default: ;
    endcase
  end

  // Request fields are frozen at acceptance so later native input changes cannot leak onto AXI.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    if (accept) begin
      addr_d    = addr & ALIGN_MASK;
      wdata_d   = wdata;
      wstrb_d   = wstrb;
      awvalid_d = |wstrb;
      wvalid_d  = |wstrb;
    end
    if (awvalid_q && m_axi_awready) begin
      awvalid_d = 1'b0;
    end
    if (wvalid_q && m_axi_wready) begin
      wvalid_d = 1'b0;
    end
    if (r_capture) begin
      rdata_d = m_axi_rdata;
    end
    if (error_clr) begin
      error_d = 1'b0;
    end
    if ((b_capture && (m_axi_bresp != RESP_OKAY)) ||
        (r_capture && (m_axi_rresp != RESP_OKAY))) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
    end
  end

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT;
  assign rdata         = rdata_q;
  assign error         = error_q;

endmodule

// File: doc/iob_cache_axil_bridge.md
# iob_cache_axil_bridge

Converts the cache back-end native memory port (valid/addr/wdata/wstrb/rdata/ready) into an AXI4-Lite master and sits directly downstream of the cache's native back-end. It lets the cache reach AXI4-Lite memories and peripherals without modification. Each native request maps to exactly one AXI4-Lite transaction, and only one transaction is ever outstanding. Slave error responses are flagged through a sticky status bit.

## Interface
Clock `clk`. Reset `reset` is synchronous and active-high. All outputs are registered or decoded from registered state.

Parameters:
- ADDR_W, 32, address width of native and AXI ports
- DATA_W, 32, data width; must be 32 or 64
- NBYTES, DATA_W/8, strobe width
- PROT, 3'b000, constant driven on awprot/arprot

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid  in  1  native request; held with addr/wdata/wstrb until ready
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- wstrb  in  NBYTES  byte enables; all-zero means read
- rdata  out  DATA_W  read data; valid when ready, held until next read completes
- ready  out  1  one-cycle completion pulse
- m_axi_awvalid / m_axi_awready  out/in  1  AW handshake
- m_axi_awaddr  out  ADDR_W  write address
- m_axi_awprot  out  3  = PROT
- m_axi_wvalid / m_axi_wready  out/in  1  W handshake
- m_axi_wdata  out  DATA_W  write data
- m_axi_wstrb  out  NBYTES  write strobes
- m_axi_bvalid / m_axi_bready  in/out  1  B handshake
- m_axi_bresp  in  2  write response
- m_axi_arvalid / m_axi_arready  out/in  1  AR handshake
- m_axi_araddr  out  ADDR_W  read address
- m_axi_arprot  out  3  = PROT
- m_axi_rvalid / m_axi_rready  in/out  1  R handshake
- m_axi_rdata  in  DATA_W  read data
- m_axi_rresp  in  2  read response
- error  out  1  sticky: a B or R response was not OKAY
- error_clr  in  1  clears error

## Operation
States are IDLE, WR, WAIT_B, RD, WAIT_R and RESP.

- **IDLE:** when valid=1, latch addr, wdata and wstrb. Force the low log2(NBYTES) address bits to zero.
  - If |wstrb=1, go to WR and set awvalid=wvalid=1.
  - Otherwise go to RD and set arvalid=1.
- **WR:** awvalid and wvalid each clear independently on their own handshake (valid&ready). Go to WAIT_B once both handshakes are complete, including when both complete in the same cycle or on different cycles.
- **WAIT_B:** bready=1. On bvalid, capture bresp and go to RESP.
- **RD:** arvalid=1. On arready, go to WAIT_R.
- **WAIT_R:** rready=1. On rvalid, load rdata from m_axi_rdata, capture rresp and go to RESP.
- **RESP:** ready=1 for exactly one cycle, then return to IDLE.
  - The native master may drop valid or present a new request in the following cycle.
  - In RESP, valid is ignored, so a request is never accepted twice.
- **AXI payload:** AXI address, data and strobe outputs come from the latched registers and are stable while the corresponding valid is high. A valid is never deasserted before its handshake.
- **Error flag:** error is set on B or R capture when resp≠2'b00, and cleared by error_clr. If set and clear happen in the same cycle, set wins. The transaction still completes normally and rdata carries whatever the slave returned.
- **Native inputs:** changes on addr, wdata or wstrb after acceptance are ignored.

## Timing
- **Reset values:** all AXI valid and ready outputs 0, ready=0, rdata=0, error=0, state IDLE. Address, data and strobe registers reset to 0.
- **Reset mid-transaction:** return to IDLE next cycle and drop all valids. The AXI slave shares the same reset.
- **Write latency:**
  - Cycle 0: valid sampled in IDLE.
  - Cycle 1: awvalid and wvalid high.
  - With zero-wait slave ready, WAIT_B is entered in cycle 2; bvalid in cycle 2 gives ready in cycle 3.
  - Minimum write: 3 cycles from valid to ready.
- **Read latency:** same pattern. Minimum read: 3 cycles from valid to ready.
- **Wait states:** each AXI wait cycle adds exactly one cycle of latency.
- **Back-to-back:** a new request held on valid in the cycle after ready is accepted in that cycle. Peak throughput is one transaction per 4 cycles.

## Test plan
- **Single write:** valid, addr=0x1003, wdata=0xDEADBEEF, wstrb=4'b0110, slave always ready, bresp=0 → awaddr=0x1000, wstrb=0110, one ready pulse exactly 3 cycles after valid, error=0.
- **Single read:** addr=0x2000, rdata from slave=0x12345678 with rvalid delayed 5 cycles → rready held for those 5 cycles, rdata=0x12345678 on the ready cycle and still held 10 cycles later.
- **Split AW/W:** awready delayed 4 cycles, wready immediate → wvalid drops after 1 cycle, awvalid holds for 4 cycles, bready rises only after both handshakes, exactly one ready.
- **Error response:** read with rresp=2'b10 → error=1 and stays 1 through a following OKAY write. Pulsing error_clr gives error=0. Driving error_clr in the same cycle as a SLVERR B response leaves error=1.
- **Back-to-back:** write then read with valid held continuously across the ready cycle → exactly two AXI transactions and two ready pulses, no duplicate AW or AR.
- **Reset mid-read:** assert reset while arvalid=1 → all outputs are at reset values next cycle, and a subsequent read completes normally.
